// File: rtl/mips_pkg.sv
// Shared MIPS datapath types used by the write-back arbiter.
package mips_pkg;

    typedef logic [4:0]  regaddr_t;
    typedef logic [31:0] word_t;

    localparam regaddr_t REG_ZERO = 5'd0;

    typedef enum logic {
        PRI_A,
        FORCE_B
    } wbarb_state_t;

endpackage

// File: rtl/regwb_arb.sv
// Write-back arbiter: shares the register file write port between the in-order
// pipeline (A) and the multi-cycle unit (B), fixed A priority with starvation override.
module regwb_arb
    import mips_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_reg,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_reg,
    input  logic [31:0] b_data,
    output logic        regwrite,
    output logic [4:0]  wrreg,
    output logic [31:0] wrdata,
    output logic        starved
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    wbarb_state_t state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         regwrite_q, regwrite_d;
    regaddr_t     wrreg_q, wrreg_d;
    word_t        wrdata_q, wrdata_d;
    logic         a_grant, b_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PRI_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            regwrite_q <= 1'b0;
            wrreg_q    <= '0;
            wrdata_q   <= '0;
        end else begin
            cnt_q      <= cnt_d;
            regwrite_q <= regwrite_d;
            wrreg_q    <= wrreg_d;
            wrdata_q   <= wrdata_d;
        end
    end

    // Force B when this A grant brings the streak up to the limit, so B wins the very next cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!b_valid || b_grant) begin
            cnt_d = '0;
        end else if (a_grant && cnt_q != 4'hF) begin
            cnt_d = cnt_q + 4'd1;
        end
        unique case (state_q)
            PRI_A:   if (b_valid && cnt_d == STARVE_LIM) state_d = FORCE_B;
            FORCE_B: if (b_grant || !b_valid)            state_d = PRI_A;
            default: state_d = PRI_A;
        endcase
    end

    // Same nonzero destination: B's result is older and must land first.
    always_comb begin
        a_grant = 1'b0;
        b_grant = 1'b0;
        if (!rst) begin
            unique case (state_q)
                PRI_A: begin
                    if (a_valid && b_valid && a_reg == b_reg && a_reg != REG_ZERO) b_grant = 1'b1;
                    else if (a_valid) a_grant = 1'b1;
                    else if (b_valid) b_grant = 1'b1;
                end
                FORCE_B: begin
                    if (b_valid)      b_grant = 1'b1;
                    else if (a_valid) a_grant = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        regwrite_d = 1'b0;
        wrreg_d    = wrreg_q;
        wrdata_d   = wrdata_q;
        if (a_grant && a_reg != REG_ZERO) begin
            regwrite_d = 1'b1;
            wrreg_d    = a_reg;
            wrdata_d   = a_data;
        end else if (b_grant && b_reg != REG_ZERO) begin
            regwrite_d = 1'b1;
            wrreg_d    = b_reg;
            wrdata_d   = b_data;
        end
    end

    assign a_ready  = a_grant;
    assign b_ready  = b_grant;
    assign starved  = (state_q == FORCE_B);
    assign regwrite = regwrite_q;
    assign wrreg    = wrreg_q;
    assign wrdata   = wrdata_q;

endmodule

// File: tb/tb_regwb_arb.sv
// Scoreboard bench for regwb_arb: expected writes are queued as grants are
// predicted and checked against the registered write port one cycle later.
module tb_regwb_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid;
    logic [4:0]  a_reg, b_reg;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, regwrite, starved;
    logic [4:0]  wrreg;
    logic [31:0] wrdata;
    logic        a1_ready, b1_ready, regwrite1, starved1;
    logic [4:0]  wrreg1;
    logic [31:0] wrdata1;

    always #5 clk = ~clk;

    regwb_arb #(.STARVE_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
        .regwrite(regwrite), .wrreg(wrreg), .wrdata(wrdata), .starved(starved)
    );

    regwb_arb #(.STARVE_MAX(1)) dut1 (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a1_ready), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b1_ready), .b_reg(b_reg), .b_data(b_data),
        .regwrite(regwrite1), .wrreg(wrreg1), .wrdata(wrdata1), .starved(starved1)
    );

    typedef struct packed {
        logic        we;
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [4:0]  hold_reg;
    logic [31:0] hold_data;
    int unsigned nvec = 0;
    int unsigned nerr = 0;

    // Predicts the registered write produced by the grant the bench expects this cycle.
    task automatic push_exp(input logic ga, input logic gb);
        wr_t e;
        e = '{we: 1'b0, r: hold_reg, d: hold_data};
        if (ga && a_reg != 5'd0)      e = '{we: 1'b1, r: a_reg, d: a_data};
        else if (gb && b_reg != 5'd0) e = '{we: 1'b1, r: b_reg, d: b_data};
        hold_reg  = e.r;
        hold_data = e.d;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h1111_1111;
        b_valid = 1'b1; b_reg = 5'd4; b_data = 32'h2222_2222;
        for (int i = 0; i < 2; i++) begin
            #1;
            nvec++;
            if ({a_ready, b_ready} !== 2'b00) begin
                nerr++;
                $display("FAIL reset_ready cyc=%0d got a=%b b=%b want a=0 b=0", i, a_ready, b_ready);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        hold_reg = '0; hold_data = '0;
        nvec++;
        if ({regwrite, wrreg, wrdata, starved} !== 39'd0) begin
            nerr++;
            $display("FAIL reset_outputs got we=%b reg=%0d data=%h starved=%b want all 0",
                     regwrite, wrreg, wrdata, starved);
        end
    endtask

    task automatic test_single_a();
        wr_t e, got;
        logic [1:0] exp_rdy [2] = '{2'b10, 2'b00};
        for (int i = 0; i < 2; i++) begin
            a_valid = (i == 0); a_reg = 5'd8; a_data = 32'hDEAD_BEEF;
            b_valid = 1'b0;
            #1;
            nvec++;
            if ({a_ready, b_ready} !== exp_rdy[i]) begin
                nerr++;
                $display("FAIL single_a_ready cyc=%0d got %b want %b", i, {a_ready, b_ready}, exp_rdy[i]);
            end
            push_exp(exp_rdy[i][1], exp_rdy[i][0]);
            @(posedge clk); #1;
            got = {regwrite, wrreg, wrdata};
            nvec++;
            if (exp_q.size() == 0) begin
                nerr++; $display("FAIL single_a_write scoreboard empty");
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    nerr++;
                    $display("FAIL single_a_write cyc=%0d got we=%b reg=%0d data=%h want we=%b reg=%0d data=%h",
                             i, got.we, got.r, got.d, e.we, e.r, e.d);
                end
            end
        end
    endtask

    task automatic test_starvation();
        wr_t e, got;
        logic exp_b;
        int unsigned nb = 0;
        for (int i = 0; i < 8; i++) begin
            exp_b = (i % 4 == 3);
            a_valid = 1'b1; a_reg = 5'd9;  a_data = 32'hA000_0000 + 32'(i);
            b_valid = 1'b1; b_reg = 5'd10; b_data = 32'hB000_0000 + 32'(nb);
            #1;
            nvec++;
            if ({a_ready, b_ready, starved} !== {~exp_b, exp_b, exp_b}) begin
                nerr++;
                $display("FAIL starve_grant cyc=%0d got a=%b b=%b starved=%b want a=%b b=%b starved=%b",
                         i, a_ready, b_ready, starved, ~exp_b, exp_b, exp_b);
            end
            push_exp(~exp_b, exp_b);
            if (exp_b) nb++;
            @(posedge clk); #1;
            got = {regwrite, wrreg, wrdata};
            nvec++;
            if (exp_q.size() == 0) begin
                nerr++; $display("FAIL starve_write scoreboard empty");
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    nerr++;
                    $display("FAIL starve_write cyc=%0d got we=%b reg=%0d data=%h want we=%b reg=%0d data=%h",
                             i, got.we, got.r, got.d, e.we, e.r, e.d);
                end
            end
        end
    endtask

    task automatic test_same_reg();
        wr_t e, got;
        logic       av [3]      = '{1'b1, 1'b1, 1'b0};
        logic       bv [3]      = '{1'b1, 1'b0, 1'b0};
        logic [1:0] exp_rdy [3] = '{2'b01, 2'b10, 2'b00};
        for (int i = 0; i < 3; i++) begin
            a_valid = av[i]; a_reg = 5'd12; a_data = 32'd1;
            b_valid = bv[i]; b_reg = 5'd12; b_data = 32'd2;
            #1;
            nvec++;
            if ({a_ready, b_ready} !== exp_rdy[i]) begin
                nerr++;
                $display("FAIL same_reg_ready cyc=%0d got %b want %b", i, {a_ready, b_ready}, exp_rdy[i]);
            end
            push_exp(exp_rdy[i][1], exp_rdy[i][0]);
            @(posedge clk); #1;
            got = {regwrite, wrreg, wrdata};
            nvec++;
            if (exp_q.size() == 0) begin
                nerr++; $display("FAIL same_reg_write scoreboard empty");
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    nerr++;
                    $display("FAIL same_reg_write cyc=%0d got we=%b reg=%0d data=%h want we=%b reg=%0d data=%h",
                             i, got.we, got.r, got.d, e.we, e.r, e.d);
                end
            end
        end
    endtask

    task automatic test_reg_zero();
        wr_t e, got;
        logic       av [5]      = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       bv [5]      = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [1:0] exp_rdy [5] = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b00};
        for (int i = 0; i < 5; i++) begin
            a_valid = av[i]; a_reg = 5'd0; a_data = 32'h66;
            b_valid = bv[i]; b_reg = 5'd0; b_data = 32'h55;
            #1;
            nvec++;
            if ({a_ready, b_ready} !== exp_rdy[i]) begin
                nerr++;
                $display("FAIL reg0_ready cyc=%0d got %b want %b", i, {a_ready, b_ready}, exp_rdy[i]);
            end
            push_exp(exp_rdy[i][1], exp_rdy[i][0]);
            @(posedge clk); #1;
            got = {regwrite, wrreg, wrdata};
            nvec++;
            if (exp_q.size() == 0) begin
                nerr++; $display("FAIL reg0_write scoreboard empty");
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    nerr++;
                    $display("FAIL reg0_write cyc=%0d got we=%b reg=%0d data=%h want we=%b reg=%0d data=%h",
                             i, got.we, got.r, got.d, e.we, e.r, e.d);
                end
            end
        end
    endtask

    // Checks only the STARVE_MAX=1 instance; the main instance is resynchronised by reset afterwards.
    task automatic test_alternate();
        logic exp_b;
        for (int i = 0; i < 6; i++) begin
            exp_b = (i % 2 == 1);
            a_valid = 1'b1; a_reg = 5'd9;  a_data = 32'hC000_0000 + 32'(i);
            b_valid = 1'b1; b_reg = 5'd10; b_data = 32'hD000_0000 + 32'(i / 2);
            #1;
            nvec++;
            if ({a1_ready, b1_ready, starved1} !== {~exp_b, exp_b, exp_b}) begin
                nerr++;
                $display("FAIL alt_grant cyc=%0d got a=%b b=%b starved=%b want a=%b b=%b starved=%b",
                         i, a1_ready, b1_ready, starved1, ~exp_b, exp_b, exp_b);
            end
            @(posedge clk); #1;
            nvec++;
            if ({regwrite1, wrreg1} !== {1'b1, (exp_b ? 5'd10 : 5'd9)}) begin
                nerr++;
                $display("FAIL alt_write cyc=%0d got we=%b reg=%0d want we=1 reg=%0d",
                         i, regwrite1, wrreg1, exp_b ? 10 : 9);
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_burst();
        wr_t e, got;
        logic exp_b;
        exp_q.delete();
        a_valid = 1'b1; a_reg = 5'd5; a_data = 32'd77; b_valid = 1'b0;
        #1;
        nvec++;
        if ({a_ready, b_ready} !== 2'b10) begin
            nerr++; $display("FAIL mid_rst_grant got %b want 10", {a_ready, b_ready});
        end
        push_exp(1'b1, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        a_reg = 5'd6; a_data = 32'd88; b_valid = 1'b1; b_reg = 5'd7; b_data = 32'd99;
        got = {regwrite, wrreg, wrdata};
        e = exp_q.pop_front();
        nvec++;
        if (got !== e) begin
            nerr++;
            $display("FAIL mid_rst_pre_write got we=%b reg=%0d data=%h want we=%b reg=%0d data=%h",
                     got.we, got.r, got.d, e.we, e.r, e.d);
        end
        #1;
        nvec++;
        if ({a_ready, b_ready} !== 2'b00) begin
            nerr++; $display("FAIL mid_rst_ready got %b want 00", {a_ready, b_ready});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        hold_reg = '0; hold_data = '0;
        nvec++;
        if ({regwrite, wrreg, wrdata, starved} !== 39'd0) begin
            nerr++;
            $display("FAIL mid_rst_outputs got we=%b reg=%0d data=%h starved=%b want all 0",
                     regwrite, wrreg, wrdata, starved);
        end
        // A full A,A,A,B run shows the arbiter restarted in PRI_A with a cleared counter.
        for (int i = 0; i < 4; i++) begin
            exp_b = (i == 3);
            #1;
            nvec++;
            if ({a_ready, b_ready, starved} !== {~exp_b, exp_b, exp_b}) begin
                nerr++;
                $display("FAIL post_rst_grant cyc=%0d got a=%b b=%b starved=%b want a=%b b=%b starved=%b",
                         i, a_ready, b_ready, starved, ~exp_b, exp_b, exp_b);
            end
            push_exp(~exp_b, exp_b);
            @(posedge clk); #1;
            got = {regwrite, wrreg, wrdata};
            nvec++;
            if (exp_q.size() == 0) begin
                nerr++; $display("FAIL post_rst_write scoreboard empty");
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    nerr++;
                    $display("FAIL post_rst_write cyc=%0d got we=%b reg=%0d data=%h want we=%b reg=%0d data=%h",
                             i, got.we, got.r, got.d, e.we, e.r, e.d);
                end
            end
            a_data = a_data + 32'd1;
        end
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_a();
        test_starvation();
        test_same_reg();
        test_reg_zero();
        test_alternate();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
